// File: rtl/wb_regport_arb_pkg.sv
// Shared widths, defaults and payload types for the writeback/long-latency regfile port arbiter.
package wb_regport_arb_pkg;

  localparam int unsigned REGIDX_W         = 5;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned LL_DEPTH_DEF     = 2;
  localparam int unsigned STARVE_W         = 3;

  typedef struct packed {
    logic [REGIDX_W-1:0] idx;
    logic [XLEN-1:0]     data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/wb_regport_arb_if.sv
// Bundles the WB request, LL handshake and regfile write port of the arbiter.
interface wb_regport_arb_if;
  import wb_regport_arb_pkg::*;

  logic                wb_wr_reg;
  logic [REGIDX_W-1:0] wb_wr_regindex;
  logic [XLEN-1:0]     wb_wr_wdata;
  logic                wb_kill;
  logic                ll_valid;
  logic [REGIDX_W-1:0] ll_regindex;
  logic [XLEN-1:0]     ll_wdata;
  logic                ll_ready;
  logic                wb_stall;
  logic                rf_wr_reg;
  logic [REGIDX_W-1:0] rf_wr_regindex;
  logic [XLEN-1:0]     rf_wr_wdata;

  modport master (
    output wb_wr_reg, wb_wr_regindex, wb_wr_wdata, wb_kill,
    output ll_valid, ll_regindex, ll_wdata,
    input  ll_ready, wb_stall, rf_wr_reg, rf_wr_regindex, rf_wr_wdata
  );

  modport slave (
    input  wb_wr_reg, wb_wr_regindex, wb_wr_wdata, wb_kill,
    input  ll_valid, ll_regindex, ll_wdata,
    output ll_ready, wb_stall, rf_wr_reg, rf_wr_regindex, rf_wr_wdata
  );

endinterface

// File: rtl/wb_regport_arb_fifo.sv
// Two-entry long-latency result buffer with head pop, per-entry index squash and ordered compaction.
module wb_ll_fifo
  import wb_regport_arb_pkg::*;
#(
  parameter int unsigned DEPTH = LL_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  rf_wr_t              push_ent,
  input  logic                pop,
  input  logic                squash,
  input  logic [REGIDX_W-1:0] squash_idx,
  output rf_wr_t              head,
  output fifo_state_e         state
);

  fifo_state_e state_d;
  rf_wr_t      ent_q [DEPTH];
  rf_wr_t      ent_d [DEPTH];
  logic        keep0;
  logic        keep1;

  // Occupancy register; valid bits are implied by the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIFO_EMPTY;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Remove popped/squashed entries, slide survivors to the head, then append the push.
  always_comb begin
    state_d = state;
    ent_d   = ent_q;
    keep0   = (state != FIFO_EMPTY) && !pop && !(squash && (ent_q[0].idx == squash_idx));
    keep1   = (state == FIFO_FULL) && !(squash && (ent_q[1].idx == squash_idx));

    if (keep0) begin
      if (keep1) begin
        state_d = FIFO_FULL;
      end else if (push) begin
        ent_d[1] = push_ent;
        state_d  = FIFO_FULL;
      end else begin
        state_d = FIFO_ONE;
      end
    end else if (keep1) begin
      ent_d[0] = ent_q[1];
      if (push) begin
        ent_d[1] = push_ent;
        state_d  = FIFO_FULL;
      end else begin
        state_d = FIFO_ONE;
      end
    end else if (push) begin
      ent_d[0] = push_ent;
      state_d  = FIFO_ONE;
    end else begin
      state_d = FIFO_EMPTY;
    end
  end

  assign head = ent_q[0];

endmodule

// File: rtl/wb_regport_arb.sv
// Shares one regfile write port between in-order writeback and a buffered long-latency result stream.
module wb_regport_arb
  import wb_regport_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned LL_DEPTH     = LL_DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  wb_regport_arb_if.slave  bus
);

  fifo_state_e         fifo_state;
  rf_wr_t              head;
  rf_wr_t              ll_ent;
  logic                wb_eff;
  logic                has_head;
  logic                starve_hit;
  logic                grant_ll;
  logic                ll_push;
  logic                wb_squash;
  logic [STARVE_W-1:0] starve_cnt;

  assign wb_eff     = bus.wb_wr_reg && !bus.wb_kill && (bus.wb_wr_regindex != '0);
  assign has_head   = (fifo_state != FIFO_EMPTY);
  assign starve_hit = (fifo_state == FIFO_FULL) && (32'(starve_cnt) >= STARVE_LIMIT);
  assign grant_ll   = has_head && (!wb_eff || starve_hit);

  // x0 results are acknowledged but never buffered.
  assign bus.ll_ready = (fifo_state != FIFO_FULL);
  assign ll_push      = bus.ll_valid && bus.ll_ready && (bus.ll_regindex != '0);
  assign ll_ent       = '{idx: bus.ll_regindex, data: bus.ll_wdata};
  assign wb_squash    = wb_eff && !grant_ll;

  wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ll_push),
    .push_ent   (ll_ent),
    .pop        (grant_ll),
    .squash     (wb_squash),
    .squash_idx (bus.wb_wr_regindex),
    .head       (head),
    .state      (fifo_state)
  );

  // Cycles the buffered head has been passed over by writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       starve_cnt <= '0;
    else if (!has_head || grant_ll)   starve_cnt <= '0;
    else if (starve_cnt != '1)        starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  // Write port mux; held quiet throughout reset so no partial write escapes.
  always_comb begin
    bus.rf_wr_reg      = 1'b0;
    bus.rf_wr_regindex = '0;
    bus.rf_wr_wdata    = '0;
    bus.wb_stall       = 1'b0;
    if (rst_n) begin
      if (grant_ll) begin
        bus.rf_wr_reg      = 1'b1;
        bus.rf_wr_regindex = head.idx;
        bus.rf_wr_wdata    = head.data;
        bus.wb_stall       = wb_eff;
      end else if (wb_eff) begin
        bus.rf_wr_reg      = 1'b1;
        bus.rf_wr_regindex = bus.wb_wr_regindex;
        bus.rf_wr_wdata    = bus.wb_wr_wdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_regport_arb.sv
// Scenario bench for wb_regport_arb: expected regfile writes are queued as stimulus is driven.
module tb_wb_regport_arb;
  import wb_regport_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  int     tests = 0;
  int     fails = 0;
  rf_wr_t exp_q [$];

  wb_regport_arb_if bus ();

  wb_regport_arb #(.STARVE_LIMIT(4), .LL_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input int idx, input logic [31:0] d, input logic kill);
    bus.wb_wr_reg      = v;
    bus.wb_wr_regindex = 5'(idx);
    bus.wb_wr_wdata    = d;
    bus.wb_kill        = kill;
  endtask

  task automatic drive_ll(input logic v, input int idx, input logic [31:0] d);
    bus.ll_valid    = v;
    bus.ll_regindex = 5'(idx);
    bus.ll_wdata    = d;
  endtask

  task automatic idle();
    drive_wb(1'b0, 0, 32'h0, 1'b0);
    drive_ll(1'b0, 0, 32'h0);
  endtask

  task automatic expect_wr(input int idx, input logic [31:0] d);
    exp_q.push_back('{idx: 5'(idx), data: d});
  endtask

  // Every regfile write must match the oldest queued expectation.
  task automatic monitor_rf();
    rf_wr_t got;
    rf_wr_t want;
    forever begin
      @(negedge clk);
      if (bus.rf_wr_reg !== 1'b0) begin
        tests++;
        got = '{idx: bus.rf_wr_regindex, data: bus.rf_wr_wdata};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rf_write: got en=%b x%0d=%h, required no write", bus.rf_wr_reg, got.idx, got.data);
        end else begin
          want = exp_q.pop_front();
          if (bus.rf_wr_reg !== 1'b1 || got !== want) begin
            fails++;
            $display("FAIL rf_write: got en=%b x%0d=%h, required x%0d=%h", bus.rf_wr_reg, got.idx, got.data, want.idx, want.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    drive_wb(1'b1, 6, 32'h66, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL reset_ll_ready: got %b, required 1", bus.ll_ready); end
    tests++;
    if (bus.wb_stall !== 1'b0) begin fails++; $display("FAIL reset_wb_stall: got %b, required 0", bus.wb_stall); end
    tests++;
    if (bus.rf_wr_reg !== 1'b0) begin fails++; $display("FAIL reset_rf_wr_reg: got %b, required 0", bus.rf_wr_reg); end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ll_idle();
    drive_ll(1'b1, 5, 32'h1234);
    expect_wr(5, 32'h1234);
    @(negedge clk);
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL ll_idle_ready0: got %b, required 1", bus.ll_ready); end
    tests++;
    if (bus.rf_wr_reg !== 1'b0) begin fails++; $display("FAIL ll_idle_latency: got %b, required 0", bus.rf_wr_reg); end
    step();
    drive_ll(1'b0, 0, 32'h0);
    @(negedge clk);
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL ll_idle_ready1: got %b, required 1", bus.ll_ready); end
    step();
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL ll_idle_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive_ll(1'b1, c + 1, 32'hC0 + 32'(c));
      else       drive_ll(1'b0, 0, 32'h0);
      if (c > 0) expect_wr(c, 32'hC0 + 32'(c - 1));
      @(negedge clk);
      tests++;
      if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready c%0d: got %b, required 1", c, bus.ll_ready); end
      step();
    end
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_starve();
    int idx;
    logic exp_stall;
    logic exp_rdy;
    idx = 16;
    for (int c = 0; c < 12; c++) begin
      exp_stall = (c == 5) || (c == 10);
      exp_rdy   = !((c >= 2 && c <= 5) || (c >= 7 && c <= 10));
      drive_wb(1'b1, idx, 32'hB00 + 32'(idx), 1'b0);
      case (c)
        0:       drive_ll(1'b1, 3, 32'h33);
        1:       drive_ll(1'b1, 4, 32'h44);
        6:       drive_ll(1'b1, 6, 32'h66);
        default: drive_ll(1'b0, 0, 32'h0);
      endcase
      if (c == 5)       expect_wr(3, 32'h33);
      else if (c == 10) expect_wr(4, 32'h44);
      else              expect_wr(idx, 32'hB00 + 32'(idx));
      @(negedge clk);
      tests++;
      if (bus.wb_stall !== exp_stall) begin fails++; $display("FAIL starve_stall c%0d: got %b, required %b", c, bus.wb_stall, exp_stall); end
      tests++;
      if (bus.ll_ready !== exp_rdy) begin fails++; $display("FAIL starve_ready c%0d: got %b, required %b", c, bus.ll_ready, exp_rdy); end
      step();
      if (!exp_stall) idx++;
    end
    idle();
    expect_wr(6, 32'h66);
    step();
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL starve_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_squash();
    // Head squashed by WB while a newer x7 arrives the same cycle.
    drive_ll(1'b1, 7, 32'hA);
    step();
    drive_wb(1'b1, 7, 32'hB, 1'b0);
    drive_ll(1'b1, 7, 32'hC);
    expect_wr(7, 32'hB);
    @(negedge clk);
    tests++;
    if (bus.wb_stall !== 1'b0) begin fails++; $display("FAIL squash_stall: got %b, required 0", bus.wb_stall); end
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL squash_ready: got %b, required 1", bus.ll_ready); end
    step();
    idle();
    expect_wr(7, 32'hC);
    step();
    // Plain squash leaves the buffer empty.
    drive_ll(1'b1, 7, 32'hD);
    step();
    drive_wb(1'b1, 7, 32'hE, 1'b0);
    drive_ll(1'b0, 0, 32'h0);
    expect_wr(7, 32'hE);
    step();
    idle();
    step();
    step();
    // Squash of the younger entry keeps the older one.
    drive_wb(1'b1, 21, 32'h121, 1'b0);
    drive_ll(1'b1, 8, 32'h81);
    expect_wr(21, 32'h121);
    step();
    drive_wb(1'b1, 22, 32'h122, 1'b0);
    drive_ll(1'b1, 9, 32'h91);
    expect_wr(22, 32'h122);
    step();
    drive_wb(1'b1, 9, 32'h99, 1'b0);
    drive_ll(1'b0, 0, 32'h0);
    expect_wr(9, 32'h99);
    @(negedge clk);
    tests++;
    if (bus.wb_stall !== 1'b0) begin fails++; $display("FAIL squash_mid_stall: got %b, required 0", bus.wb_stall); end
    step();
    idle();
    expect_wr(8, 32'h81);
    step();
    step();
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL squash_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_kill();
    drive_ll(1'b1, 9, 32'h900);
    step();
    drive_ll(1'b0, 0, 32'h0);
    drive_wb(1'b1, 12, 32'h12, 1'b1);
    expect_wr(9, 32'h900);
    @(negedge clk);
    tests++;
    if (bus.wb_stall !== 1'b0) begin fails++; $display("FAIL kill_stall: got %b, required 0", bus.wb_stall); end
    step();
    @(negedge clk);
    tests++;
    if (bus.rf_wr_reg !== 1'b0) begin fails++; $display("FAIL kill_empty_write: got %b, required 0", bus.rf_wr_reg); end
    step();
    idle();
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL kill_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_x0();
    drive_ll(1'b1, 0, 32'hDEAD);
    @(negedge clk);
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL x0_ll_ready: got %b, required 1", bus.ll_ready); end
    step();
    drive_ll(1'b0, 0, 32'h0);
    drive_wb(1'b1, 0, 32'hBEEF, 1'b0);
    @(negedge clk);
    tests++;
    if (bus.rf_wr_reg !== 1'b0) begin fails++; $display("FAIL x0_wb_write: got %b, required 0", bus.rf_wr_reg); end
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL x0_not_buffered: got ll_ready %b, required 1", bus.ll_ready); end
    step();
    idle();
    step();
    step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL x0_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, 23, 32'h230, 1'b0);
    drive_ll(1'b1, 13, 32'h13);
    expect_wr(23, 32'h230);
    step();
    drive_wb(1'b1, 24, 32'h240, 1'b0);
    drive_ll(1'b1, 14, 32'h14);
    expect_wr(24, 32'h240);
    step();
    drive_wb(1'b1, 25, 32'h250, 1'b0);
    drive_ll(1'b0, 0, 32'h0);
    expect_wr(25, 32'h250);
    @(negedge clk);
    tests++;
    if (bus.ll_ready !== 1'b0) begin fails++; $display("FAIL rstmid_full: got ll_ready %b, required 0", bus.ll_ready); end
    #2;
    rst_n = 1'b0;
    drive_wb(1'b1, 26, 32'h260, 1'b0);
    #1;
    tests++;
    if (bus.rf_wr_reg !== 1'b0) begin fails++; $display("FAIL rstmid_rf_wr_reg: got %b, required 0", bus.rf_wr_reg); end
    tests++;
    if (bus.ll_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ll_ready: got %b, required 1", bus.ll_ready); end
    tests++;
    if (bus.wb_stall !== 1'b0) begin fails++; $display("FAIL rstmid_wb_stall: got %b, required 0", bus.wb_stall); end
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    repeat (6) step();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_drain: got %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    fork
      monitor_rf();
    join_none
    test_reset();
    test_ll_idle();
    test_back_to_back();
    test_starve();
    test_squash();
    test_kill();
    test_x0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
